// File: rtl/pipe_pkg.sv
// Constants shared by the stage-register bank and the hazard/control unit.
package pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 8;
  localparam logic [4:0]  REG_X0     = 5'd0;
  localparam int unsigned BR_BIT     = 0;

  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

  // A slot that is a bubble or does not write rd must look like x0 to hazard logic.
  function automatic logic [4:0] gate_rd(input logic       valid,
                                         input logic       wr,
                                         input logic [4:0] rd);
    return (valid && wr) ? rd : REG_X0;
  endfunction

endpackage

// File: rtl/pipe_latch.sv
// Generic pipeline latch: flush injects an all-zero bubble, enable loads, otherwise hold.
module pipe_latch #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (en_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipeline_stage_regs.sv
// F/D, D/R, R/E and E/W stage registers of the 5-stage core, with hazard-facing
// rd gating, branch indication and wrap-around performance counters.
module pipeline_stage_regs
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ILEN   = 32,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pc_F,
  input  logic [ILEN-1:0]   instr_F,
  input  logic              valid_F,
  input  logic [4:0]        rs1_D,
  input  logic [4:0]        rs2_D,
  input  logic [4:0]        rd_D,
  input  logic              reg_flag_D,
  input  logic [CTRL_W-1:0] ctrl_D,
  input  logic [XLEN-1:0]   op_a_R,
  input  logic [XLEN-1:0]   op_b_R,
  input  logic [XLEN-1:0]   result_E,
  input  logic              branch_cond_E,
  input  logic              enable_F_D,
  input  logic              enable_D_R,
  input  logic              enable_R_E,
  input  logic              enable_E_W,
  input  logic              flush_F_D,
  input  logic              flush_D_R,
  input  logic              flush_R_E,
  input  logic              flush_E_W,
  output logic [XLEN-1:0]   pc_D,
  output logic [ILEN-1:0]   instr_D,
  output logic              valid_D,
  output logic [4:0]        rs1_R,
  output logic [4:0]        rs2_R,
  output logic [4:0]        rd_R,
  output logic [CTRL_W-1:0] ctrl_R,
  output logic [XLEN-1:0]   pc_R,
  output logic              valid_R,
  output logic [XLEN-1:0]   op_a_E,
  output logic [XLEN-1:0]   op_b_E,
  output logic [4:0]        rd_E,
  output logic [CTRL_W-1:0] ctrl_E,
  output logic [XLEN-1:0]   pc_E,
  output logic              valid_E,
  output logic              branch_E,
  output logic [4:0]        rd_W,
  output logic [XLEN-1:0]   result_W,
  output logic              reg_flag_W,
  output logic              valid_W,
  output logic [CNT_W-1:0]  cnt_cycle,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_flush,
  output logic [CNT_W-1:0]  cnt_retire
);

  localparam int unsigned FD_W = XLEN + ILEN;
  localparam int unsigned DR_W = 5 + 5 + 5 + 1 + CTRL_W + XLEN;
  localparam int unsigned RE_W = XLEN + XLEN + 5 + 1 + CTRL_W + XLEN;
  localparam int unsigned EW_W = 5 + 1 + XLEN;

  logic [FD_W-1:0] fd_q;
  logic [DR_W-1:0] dr_q;
  logic [RE_W-1:0] re_q;
  logic [EW_W-1:0] ew_q;

  logic [4:0] rs1_raw_R, rs2_raw_R, rd_raw_R, rd_raw_E, rd_raw_W;
  logic       flag_R, flag_E, flag_W;

  pipe_latch #(.W(FD_W)) u_fd (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (enable_F_D),
    .flush_i (flush_F_D),
    .valid_i (valid_F),
    .data_i  ({pc_F, instr_F}),
    .valid_o (valid_D),
    .data_o  (fd_q)
  );
  assign {pc_D, instr_D} = fd_q;

  pipe_latch #(.W(DR_W)) u_dr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (enable_D_R),
    .flush_i (flush_D_R),
    .valid_i (valid_D),
    .data_i  ({rs1_D, rs2_D, rd_D, reg_flag_D, ctrl_D, pc_D}),
    .valid_o (valid_R),
    .data_o  (dr_q)
  );
  assign {rs1_raw_R, rs2_raw_R, rd_raw_R, flag_R, ctrl_R, pc_R} = dr_q;

  assign rs1_R = valid_R ? rs1_raw_R : REG_X0;
  assign rs2_R = valid_R ? rs2_raw_R : REG_X0;
  assign rd_R  = gate_rd(valid_R, flag_R, rd_raw_R);

  // Raw rd/reg_flag travel down the pipe; gating is reapplied at each stage's own valid.
  pipe_latch #(.W(RE_W)) u_re (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (enable_R_E),
    .flush_i (flush_R_E),
    .valid_i (valid_R),
    .data_i  ({op_a_R, op_b_R, rd_raw_R, flag_R, ctrl_R, pc_R}),
    .valid_o (valid_E),
    .data_o  (re_q)
  );
  assign {op_a_E, op_b_E, rd_raw_E, flag_E, ctrl_E, pc_E} = re_q;

  assign rd_E     = gate_rd(valid_E, flag_E, rd_raw_E);
  assign branch_E = branch_cond_E & valid_E & ctrl_E[BR_BIT];

  pipe_latch #(.W(EW_W)) u_ew (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (enable_E_W),
    .flush_i (flush_E_W),
    .valid_i (valid_E),
    .data_i  ({rd_raw_E, flag_E, result_E}),
    .valid_o (valid_W),
    .data_o  (ew_q)
  );
  assign {rd_raw_W, flag_W, result_W} = ew_q;

  assign reg_flag_W = valid_W & flag_W;
  assign rd_W       = gate_rd(valid_W, flag_W, rd_raw_W);

  logic [CNT_W-1:0] cnt_cycle_q,  cnt_cycle_d;
  logic [CNT_W-1:0] cnt_stall_q,  cnt_stall_d;
  logic [CNT_W-1:0] cnt_flush_q,  cnt_flush_d;
  logic [CNT_W-1:0] cnt_retire_q, cnt_retire_d;
  logic             stall_ev, flush_ev, retire_ev;

  assign stall_ev  = ~enable_F_D & ~flush_F_D;
  assign flush_ev  = flush_F_D | flush_D_R | flush_R_E | flush_E_W;
  assign retire_ev = valid_W & enable_E_W;

  always_comb begin
    cnt_cycle_d  = cnt_cycle_q  + CNT_W'(1);
    cnt_stall_d  = cnt_stall_q  + CNT_W'(stall_ev);
    cnt_flush_d  = cnt_flush_q  + CNT_W'(flush_ev);
    cnt_retire_d = cnt_retire_q + CNT_W'(retire_ev);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_cycle_q  <= '0;
      cnt_stall_q  <= '0;
      cnt_flush_q  <= '0;
      cnt_retire_q <= '0;
    end else begin
      cnt_cycle_q  <= cnt_cycle_d;
      cnt_stall_q  <= cnt_stall_d;
      cnt_flush_q  <= cnt_flush_d;
      cnt_retire_q <= cnt_retire_d;
    end
  end

  assign cnt_cycle  = cnt_cycle_q;
  assign cnt_stall  = cnt_stall_q;
  assign cnt_flush  = cnt_flush_q;
  assign cnt_retire = cnt_retire_q;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Directed bench for pipeline_stage_regs: a vector table plus hand-written multi-cycle sequences.
module tb_pipeline_stage_regs;

  logic        clk, rst_n;
  logic [31:0] pc_F, instr_F, op_a_R, op_b_R, result_E;
  logic        valid_F, reg_flag_D, branch_cond_E;
  logic [4:0]  rs1_D, rs2_D, rd_D;
  logic [7:0]  ctrl_D;
  logic        enable_F_D, enable_D_R, enable_R_E, enable_E_W;
  logic        flush_F_D, flush_D_R, flush_R_E, flush_E_W;

  logic [31:0] pc_D, instr_D, pc_R, op_a_E, op_b_E, pc_E, result_W;
  logic        valid_D, valid_R, valid_E, branch_E, reg_flag_W, valid_W;
  logic [4:0]  rs1_R, rs2_R, rd_R, rd_E, rd_W;
  logic [7:0]  ctrl_R, ctrl_E;
  logic [31:0] cnt_cycle, cnt_stall, cnt_flush, cnt_retire;

  logic [31:0] pc_D4, instr_D4, pc_R4, op_a_E4, op_b_E4, pc_E4, result_W4;
  logic        valid_D4, valid_R4, valid_E4, branch_E4, reg_flag_W4, valid_W4;
  logic [4:0]  rs1_R4, rs2_R4, rd_R4, rd_E4, rd_W4;
  logic [7:0]  ctrl_R4, ctrl_E4;
  logic [3:0]  cnt_cycle4, cnt_stall4, cnt_flush4, cnt_retire4;

  int unsigned total = 0;
  int unsigned bad   = 0;

  pipeline_stage_regs dut (
    .clk(clk), .rst_n(rst_n), .pc_F(pc_F), .instr_F(instr_F), .valid_F(valid_F),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .reg_flag_D(reg_flag_D), .ctrl_D(ctrl_D),
    .op_a_R(op_a_R), .op_b_R(op_b_R), .result_E(result_E), .branch_cond_E(branch_cond_E),
    .enable_F_D(enable_F_D), .enable_D_R(enable_D_R), .enable_R_E(enable_R_E), .enable_E_W(enable_E_W),
    .flush_F_D(flush_F_D), .flush_D_R(flush_D_R), .flush_R_E(flush_R_E), .flush_E_W(flush_E_W),
    .pc_D(pc_D), .instr_D(instr_D), .valid_D(valid_D),
    .rs1_R(rs1_R), .rs2_R(rs2_R), .rd_R(rd_R), .ctrl_R(ctrl_R), .pc_R(pc_R), .valid_R(valid_R),
    .op_a_E(op_a_E), .op_b_E(op_b_E), .rd_E(rd_E), .ctrl_E(ctrl_E), .pc_E(pc_E), .valid_E(valid_E),
    .branch_E(branch_E), .rd_W(rd_W), .result_W(result_W), .reg_flag_W(reg_flag_W), .valid_W(valid_W),
    .cnt_cycle(cnt_cycle), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush), .cnt_retire(cnt_retire)
  );

  pipeline_stage_regs #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pc_F(pc_F), .instr_F(instr_F), .valid_F(valid_F),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .reg_flag_D(reg_flag_D), .ctrl_D(ctrl_D),
    .op_a_R(op_a_R), .op_b_R(op_b_R), .result_E(result_E), .branch_cond_E(branch_cond_E),
    .enable_F_D(enable_F_D), .enable_D_R(enable_D_R), .enable_R_E(enable_R_E), .enable_E_W(enable_E_W),
    .flush_F_D(flush_F_D), .flush_D_R(flush_D_R), .flush_R_E(flush_R_E), .flush_E_W(flush_E_W),
    .pc_D(pc_D4), .instr_D(instr_D4), .valid_D(valid_D4),
    .rs1_R(rs1_R4), .rs2_R(rs2_R4), .rd_R(rd_R4), .ctrl_R(ctrl_R4), .pc_R(pc_R4), .valid_R(valid_R4),
    .op_a_E(op_a_E4), .op_b_E(op_b_E4), .rd_E(rd_E4), .ctrl_E(ctrl_E4), .pc_E(pc_E4), .valid_E(valid_E4),
    .branch_E(branch_E4), .rd_W(rd_W4), .result_W(result_W4), .reg_flag_W(reg_flag_W4), .valid_W(valid_W4),
    .cnt_cycle(cnt_cycle4), .cnt_stall(cnt_stall4), .cnt_flush(cnt_flush4), .cnt_retire(cnt_retire4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] rs1, rs2, rd;
    logic       flag;
    logic [7:0] ctrl;
    logic       cond;
    logic [4:0] e_rs1, e_rs2, e_rd_R, e_rd_E;
    logic       e_br;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    {enable_F_D, enable_D_R, enable_R_E, enable_E_W} = 4'b1111;
    {flush_F_D, flush_D_R, flush_R_E, flush_E_W}     = 4'b0000;
    valid_F = 1'b0; pc_F = '0; instr_F = '0;
    rs1_D = '0; rs2_D = '0; rd_D = '0; reg_flag_D = 1'b0; ctrl_D = '0;
    op_a_R = '0; op_b_R = '0; result_E = '0; branch_cond_E = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valids"}, {valid_D, valid_R, valid_E, valid_W}, 4'b0000);
    check({tag, "_rds"},    {rd_R, rd_E, rd_W}, 15'd0);
    check({tag, "_data"},   {instr_D, pc_E, result_W, 7'd0, reg_flag_W, ctrl_E}, 112'd0);
    check({tag, "_cnts"},   {cnt_cycle, cnt_stall, cnt_flush, cnt_retire}, 128'd0);
    check({tag, "_cnt4"},   cnt_cycle4, 4'd0);
  endtask

  // Assert reset off the clock edge, check asynchronously, release on a falling edge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd3,  5'd4,  5'd5,  1'b1, 8'h01, 1'b1, 5'd3,  5'd4,  5'd5,  5'd5,  1'b1};
    vecs[1] = '{1'b1, 5'd1,  5'd2,  5'd9,  1'b0, 8'h01, 1'b0, 5'd1,  5'd2,  5'd0,  5'd0,  1'b0};
    vecs[2] = '{1'b0, 5'd7,  5'd8,  5'd10, 1'b1, 8'h01, 1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  1'b0};
    vecs[3] = '{1'b1, 5'd31, 5'd0,  5'd31, 1'b1, 8'hFE, 1'b1, 5'd31, 5'd0,  5'd31, 5'd31, 1'b0};
    vecs[4] = '{1'b1, 5'd0,  5'd17, 5'd0,  1'b1, 8'hFF, 1'b1, 5'd0,  5'd17, 5'd0,  5'd0,  1'b1};
    vecs[5] = '{1'b1, 5'd5,  5'd6,  5'd12, 1'b1, 8'h01, 1'b0, 5'd5,  5'd6,  5'd12, 5'd12, 1'b0};

    set_idle();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1 check_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      valid_F = vecs[i].valid;
      tick();
      rs1_D = vecs[i].rs1; rs2_D = vecs[i].rs2; rd_D = vecs[i].rd;
      reg_flag_D = vecs[i].flag; ctrl_D = vecs[i].ctrl;
      tick();
      check($sformatf("v%0d_rs1_R", i), rs1_R, vecs[i].e_rs1);
      check($sformatf("v%0d_rs2_R", i), rs2_R, vecs[i].e_rs2);
      check($sformatf("v%0d_rd_R", i),  rd_R,  vecs[i].e_rd_R);
      branch_cond_E = vecs[i].cond;
      tick();
      check($sformatf("v%0d_rd_E", i),     rd_E,     vecs[i].e_rd_E);
      check($sformatf("v%0d_branch_E", i), branch_E, vecs[i].e_br);
    end

    valid_F = 1'b1;
    do_reset("midrst");

    // Straight-line flow: one instruction through all four latches.
    valid_F = 1'b1; pc_F = 32'h100; instr_F = 32'hDEAD_0013;
    tick();
    check("sl_valid_D", valid_D, 1'b1);
    check("sl_instr_D", instr_D, 32'hDEAD_0013);
    valid_F = 1'b0; rd_D = 5'd5; reg_flag_D = 1'b1;
    tick();
    check("sl_rd_R", rd_R, 5'd5);
    check("sl_pc_R", pc_R, 32'h100);
    rd_D = 5'd0; reg_flag_D = 1'b0; op_a_R = 32'hAAAA_5555;
    tick();
    check("sl_rd_E", rd_E, 5'd5);
    check("sl_op_a_E", op_a_E, 32'hAAAA_5555);
    result_E = 32'h1234;
    tick();
    check("sl_rd_W", rd_W, 5'd5);
    check("sl_reg_flag_W", reg_flag_W, 1'b1);
    check("sl_result_W", result_W, 32'h1234);
    check("sl_retire_e4", cnt_retire, 32'd0);
    tick();
    check("sl_retire_e5", cnt_retire, 32'd1);
    check("sl_cycle_e5", cnt_cycle, 32'd5);
    check("sl_valid_W_e5", valid_W, 1'b0);

    // Stall F/D while D/R is flushed for two cycles.
    do_reset("rst_stall");
    valid_F = 1'b1; instr_F = 32'h0000_0AAA;
    tick();
    enable_F_D = 1'b0; flush_D_R = 1'b1;
    instr_F = 32'h0000_0BBB; rd_D = 5'd7; reg_flag_D = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("st%0d_instr_D", c), instr_D, 32'h0000_0AAA);
      check($sformatf("st%0d_valid_D", c), valid_D, 1'b1);
      check($sformatf("st%0d_valid_R", c), valid_R, 1'b0);
      check($sformatf("st%0d_rd_R", c),    rd_R,    5'd0);
    end
    check("st_cnt_stall", cnt_stall, 32'd2);
    check("st_cnt_flush", cnt_flush, 32'd2);

    // Flush beats enable on R/E.
    do_reset("rst_fbe");
    valid_F = 1'b1;
    tick();
    valid_F = 1'b0; rd_D = 5'd7; reg_flag_D = 1'b1;
    tick();
    check("fbe_rd_R", rd_R, 5'd7);
    flush_R_E = 1'b1;
    tick();
    check("fbe_valid_E", valid_E, 1'b0);
    check("fbe_rd_E", rd_E, 5'd0);
    check("fbe_cnt_flush", cnt_flush, 32'd1);
    check("fbe_cnt_stall", cnt_stall, 32'd0);

    // Simultaneous flush of every latch, then the next fetch enters F/D.
    set_idle();
    valid_F = 1'b1; instr_F = 32'h0000_0CCC;
    tick();
    {flush_F_D, flush_D_R, flush_R_E, flush_E_W} = 4'b1111;
    tick();
    check("fall_valids", {valid_D, valid_R, valid_E, valid_W}, 4'b0000);
    check("fall_cnt_flush", cnt_flush, 32'd2);
    {flush_F_D, flush_D_R, flush_R_E, flush_E_W} = 4'b0000;
    instr_F = 32'h0000_0DDD;
    tick();
    check("fall_valid_D", valid_D, 1'b1);
    check("fall_instr_D", instr_D, 32'h0000_0DDD);

    // Counter wrap on the 4-bit instance.
    do_reset("rst_wrap");
    for (int c = 0; c < 17; c++) tick();
    check("wrap_cnt4", cnt_cycle4, 4'd1);
    check("wrap_cnt32", cnt_cycle, 32'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_regs.md
Name: pipeline_stage_regs

Overview:
- Stage-register bank of the 5-stage core: F/D, D/R, R/E and E/W latches.
- Consumes the enable_*/flush_* controls from the hazard/control unit and returns the per-stage destination-register and branch indications that unit needs.
- Includes bubble-aware rd gating, so invalid or non-writing slots never raise false RAW hazards.
- Includes wrap-around performance counters for cycles, stalls, flushes and retired instructions.

Parameters:
- XLEN, 32, data/PC width.
- ILEN, 32, instruction width.
- CTRL_W, 8, width of decoded control bundle carried D to W.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  single core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_F  in  XLEN  fetch PC.
- instr_F  in  ILEN  fetched instruction.
- valid_F  in  1  fetch slot holds a real instruction.
- rs1_D, rs2_D, rd_D  in  5 each  decoded register indices.
- reg_flag_D  in  1  decoded instruction writes rd.
- ctrl_D  in  CTRL_W  decoded control bundle.
- op_a_R, op_b_R  in  XLEN each  operands read in R.
- result_E  in  XLEN  execute result.
- branch_cond_E  in  1  execute resolved branch as taken.
- enable_F_D, enable_D_R, enable_R_E, enable_E_W  in  1 each  latch load enables.
- flush_F_D, flush_D_R, flush_R_E, flush_E_W  in  1 each  latch bubble injects.
- pc_D, instr_D, valid_D  out  XLEN/ILEN/1  F/D contents.
- rs1_R, rs2_R, rd_R, ctrl_R, pc_R, valid_R  out  D/R contents.
- op_a_E, op_b_E, rd_E, ctrl_E, pc_E, valid_E  out  R/E contents.
- branch_E  out  1  branch_cond_E AND valid_E AND ctrl_E[BR_BIT].
- rd_W, result_W, reg_flag_W, valid_W  out  E/W contents.
- cnt_cycle, cnt_stall, cnt_flush, cnt_retire  out  CNT_W each  performance counters.

Behaviour:
- Reset: asynchronous on rst_n low. Every latch field, every valid bit and every counter clears to 0. All outputs read 0 while reset is held and immediately after it.
- Per-latch update at each rising clk edge, in priority order:
  - flush=1: load bubble (valid=0, rd=0, reg_flag=0, ctrl=0, pc/instr/data=0). Flush overrides enable.
  - else enable=1: load the upstream stage contents.
  - else: hold.
- Latency: an instruction needs 1 cycle per stage, so 4 edges from F inputs to E/W when unstalled.
- rd gating: rd_R, rd_E and rd_W are driven as (valid AND reg_flag) ? rd : 5'd0, so a bubble or a non-writing instruction presents x0. rs1_R and rs2_R are driven 0 when valid_R=0.
- reg_flag_W = valid_W AND latched reg_flag. The register file writes only when it is 1.
- branch_E is combinational from the R/E latch plus branch_cond_E, with no extra register.
- Stalled latch (enable=0, flush=0) with upstream flushed: the held content is preserved. Only its own flush clears it.
- Simultaneous flush on all latches: every stage becomes a bubble in the same edge. The next valid_F enters F/D on the following edge.
- Counters, each CNT_W bits, wrapping modulo 2^CNT_W with no saturation:
  - cnt_cycle: +1 every edge out of reset.
  - cnt_stall: +1 per edge with enable_F_D=0 and flush_F_D=0.
  - cnt_flush: +1 per edge with any flush_* asserted. At most +1 per edge.
  - cnt_retire: +1 per edge where valid_W=1 and enable_E_W=1, meaning the W slot is consumed.
- Reset mid-operation: all stages become bubbles and the counters clear. No partial state survives.

Decomposition:
- Shared package pipe_pkg: REG_X0=5'd0, BR_BIT index into ctrl, CTRL_W default, and the bubble constant for the ctrl bundle. The hazard/control unit imports the same constants.
- One generic sub-module, pipe_latch (parameterised width, with enable, flush and valid), instantiated four times.
- The counters sit inline in the top module.

Test Plan:
- Reset: drive rst_n=0 mid-stream with valid contents in all latches -> all valid_*=0, rd_*=0 and counters=0 immediately, without waiting for clk.
- Straight-line flow: valid instruction with rd_D=5, reg_flag_D=1 at cycle 0 and all enables=1 -> rd_R=5 at edge 2, rd_E=5 at edge 3, rd_W=5 at edge 4 with reg_flag_W=1, then cnt_retire=1 after edge 5.
- Stall: hold enable_F_D=0 with flush_D_R=1 for 2 cycles -> instr_D unchanged, valid_R=0 and rd_R=0 for both cycles, cnt_stall=2.
- Flush beats enable: enable_R_E=1 and flush_R_E=1 with valid D/R rd=7 -> valid_E=0 and rd_E=0 after the edge, cnt_flush +1.
- Branch: valid_E=1, ctrl_E[BR_BIT]=1, branch_cond_E=1 -> branch_E=1 in the same cycle. With branch_cond_E=0, or with valid_E=0, -> branch_E=0.
- Counter wrap: with CNT_W=4, run 17 cycles -> cnt_cycle=1.
